// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath.
// The master side is the controller, the slave side is the datapath.
interface mc_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemRd;
    logic       MemWr;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegDst;
    logic       RegWr;
    logic       MemtoReg;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, zero, mem_ready,
        output IorD, MemRd, MemWr, IRWrite, PCWrite, PCWriteCond, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWr, MemtoReg,
               instr_done, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  IorD, MemRd, MemWr, IRWrite, PCWrite, PCWriteCond, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWr, MemtoReg,
               instr_done, illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// write-back and stalls on the memory ready handshake.
module mc_ctrl (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_if.master     bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } StateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    StateT      r_state;
    logic [5:0] r_opQ;
    logic       w_supported;

    assign w_supported = (bus.op == OP_RTYPE) || (bus.op == OP_LW) ||
                         (bus.op == OP_SW) || (bus.op == OP_BEQ) ||
                         (bus.op == OP_J);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_opQ   <= 6'd0;
        end else begin
            case (r_state)
                S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_opQ <= bus.op;
                    case (bus.op)
                        OP_RTYPE:    r_state <= S_EXEC;
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_BEQ:      r_state <= S_BRANCH;
                        OP_J:        r_state <= S_JUMP;
                        default:     r_state <= S_FETCH;
                    endcase
                end
                // Routing after DECODE relies on the latched opcode only.
                S_MEMADR: r_state <= (r_opQ == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the state; reset forces everything low, including the
    // mem_ready and op dependent terms.
    always_comb begin
        bus.IorD        = 1'b0;
        bus.MemRd       = 1'b0;
        bus.MemWr       = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSrc       = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.RegDst      = 1'b0;
        bus.RegWr       = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.MemRd   = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcB    = 2'b11;
                    bus.illegal    = !w_supported;
                    bus.instr_done = !w_supported;
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRd = 1'b1;
                    bus.IorD  = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWr      = 1'b1;
                    bus.MemtoReg   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWr      = 1'b1;
                    bus.IorD       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    bus.RegWr      = 1'b1;
                    bus.RegDst     = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCSrc       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.instr_done  = 1'b1;
                end
                S_JUMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSrc      = 2'b10;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instructions plus randomized
// instruction streams with random stalls and reset aborts.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    mc_ctrl_if bus();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Control word layout: IorD MemRd MemWr IRWrite PCWrite PCWriteCond
    // PCSrc[1:0] ALUSrcA ALUSrcB[1:0] ALUOp[1:0] RegDst RegWr MemtoReg
    // instr_done illegal.
    localparam logic [17:0] C_IORD   = 18'd1 << 17;
    localparam logic [17:0] C_MEMRD  = 18'd1 << 16;
    localparam logic [17:0] C_MEMWR  = 18'd1 << 15;
    localparam logic [17:0] C_IRW    = 18'd1 << 14;
    localparam logic [17:0] C_PCW    = 18'd1 << 13;
    localparam logic [17:0] C_PCWC   = 18'd1 << 12;
    localparam logic [17:0] C_PCS_OUT = 18'd1 << 10;
    localparam logic [17:0] C_PCS_J  = 18'd2 << 10;
    localparam logic [17:0] C_SRCA   = 18'd1 << 9;
    localparam logic [17:0] C_SRCB_4 = 18'd1 << 7;
    localparam logic [17:0] C_SRCB_I = 18'd2 << 7;
    localparam logic [17:0] C_SRCB_S = 18'd3 << 7;
    localparam logic [17:0] C_ALU_SUB = 18'd1 << 5;
    localparam logic [17:0] C_ALU_FN = 18'd2 << 5;
    localparam logic [17:0] C_RDST   = 18'd1 << 4;
    localparam logic [17:0] C_REGW   = 18'd1 << 3;
    localparam logic [17:0] C_M2R    = 18'd1 << 2;
    localparam logic [17:0] C_DONE   = 18'd1 << 1;
    localparam logic [17:0] C_ILL    = 18'd1;

    string       stepName[$];
    logic [17:0] stepBase[$];
    logic [17:0] stepExtra[$];
    bit          stepWait[$];

    function automatic logic [17:0] packCtl();
        return {bus.IorD, bus.MemRd, bus.MemWr, bus.IRWrite, bus.PCWrite,
                bus.PCWriteCond, bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUOp, bus.RegDst, bus.RegWr, bus.MemtoReg,
                bus.instr_done, bus.illegal};
    endfunction

    function automatic bit isSupported(input logic [5:0] opc);
        return opc == 6'b000000 || opc == 6'b100011 || opc == 6'b101011 ||
               opc == 6'b000100 || opc == 6'b000010;
    endfunction

    // Cycles from entering FETCH through instr_done with no stalls.
    function automatic int baseLatency(input logic [5:0] opc);
        case (opc)
            6'b000000: return 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic addStep(input string name, input logic [17:0] base,
                           input bit waits, input logic [17:0] extra);
        stepName.push_back(name);
        stepBase.push_back(base);
        stepWait.push_back(waits);
        stepExtra.push_back(extra);
    endtask

    // Expected per-cycle control words of one instruction; memory steps
    // repeat while mem_ready is low and add their extra terms when it is high.
    task automatic buildPlan(input logic [5:0] opc);
        stepName.delete(); stepBase.delete(); stepWait.delete(); stepExtra.delete();
        addStep("fetch", C_MEMRD | C_SRCB_4, 1'b1, C_IRW | C_PCW);
        if (!isSupported(opc)) begin
            addStep("decode_illegal", C_SRCB_S | C_ILL | C_DONE, 1'b0, '0);
            return;
        end
        addStep("decode", C_SRCB_S, 1'b0, '0);
        case (opc)
            6'b000000: begin
                addStep("exec", C_SRCA | C_ALU_FN, 1'b0, '0);
                addStep("aluwb", C_REGW | C_RDST | C_DONE, 1'b0, '0);
            end
            6'b100011: begin
                addStep("memadr", C_SRCA | C_SRCB_I, 1'b0, '0);
                addStep("memrd", C_MEMRD | C_IORD, 1'b1, '0);
                addStep("memwb", C_REGW | C_M2R | C_DONE, 1'b0, '0);
            end
            6'b101011: begin
                addStep("memadr", C_SRCA | C_SRCB_I, 1'b0, '0);
                addStep("memwr", C_MEMWR | C_IORD, 1'b1, C_DONE);
            end
            6'b000100:
                addStep("branch", C_SRCA | C_ALU_SUB | C_PCS_OUT | C_PCWC | C_DONE,
                        1'b0, '0);
            default:
                addStep("jump", C_PCW | C_PCS_J | C_DONE, 1'b0, '0);
        endcase
    endtask

    // Runs one instruction from FETCH; abortStep >= 0 asserts rst in the
    // first cycle of that step and abandons the instruction.
    task automatic applyStimulus(input logic [5:0] opc, input int readyPct,
                                 input int forcedStalls, input int abortStep);
        int          cycles;
        int          totalStalls;
        int          stalls;
        bit          advance;
        bit          rdy;
        logic [17:0] expected;
        buildPlan(opc);
        cycles      = 0;
        totalStalls = 0;
        for (int s = 0; s < stepName.size(); s++) begin
            stalls  = 0;
            advance = 1'b0;
            while (!advance) begin
                if (stepWait[s] && stalls < forcedStalls) rdy = 1'b0;
                else if (stalls >= 6) rdy = 1'b1;
                else rdy = ($urandom_range(99) < readyPct);
                bus.mem_ready = rdy;
                bus.zero      = 1'($urandom_range(1));
                bus.op        = (s == 1) ? opc : 6'($urandom);
                if (s == abortStep) begin
                    rst = 1'b1;
                    @(negedge clk);
                    checkOutput({"abort_", stepName[s]}, 32'(packCtl()), 32'd0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
                @(negedge clk);
                cycles++;
                expected = stepBase[s] | (rdy ? stepExtra[s] : 18'd0);
                checkOutput(stepName[s], 32'(packCtl()), 32'(expected));
                @(posedge clk); #1;
                advance = !stepWait[s] || rdy;
                if (!advance) begin
                    stalls++;
                    totalStalls++;
                end
            end
        end
        checkOutput("latency", 32'(cycles), 32'(baseLatency(opc) + totalStalls));
    endtask

    function automatic logic [5:0] randomOp();
        logic [5:0] opc;
        case ($urandom_range(5))
            0: opc = 6'b000000;
            1: opc = 6'b100011;
            2: opc = 6'b101011;
            3: opc = 6'b000100;
            4: opc = 6'b000010;
            default: begin
                opc = 6'($urandom);
                while (isSupported(opc)) opc = 6'($urandom);
            end
        endcase
        return opc;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.op        = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset", 32'(packCtl()), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        applyStimulus(6'b000000, 100, 0, -1);
        applyStimulus(6'b100011, 100, 2, -1);
        applyStimulus(6'b101011, 60, 1, -1);
        applyStimulus(6'b000100, 100, 0, -1);
        applyStimulus(6'b000010, 100, 0, -1);
        applyStimulus(6'b111111, 100, 0, -1);
        applyStimulus(6'b100011, 100, 0, 4);
        applyStimulus(6'b000000, 100, 0, -1);

        for (int n = 0; n < 200; n++) begin
            int abortAt;
            abortAt = ($urandom_range(9) == 0) ? int'($urandom_range(4)) : -1;
            applyStimulus(randomOp(), 70, 0, abortAt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore-style state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It drives the shared-memory, IR, PC, register-file and ALU-input controls, and stalls on a memory ready handshake. It supports R-type, LW, SW, BEQ and J; any other opcode is flagged and skipped.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- op  input  6  opcode, IR[31:26]; valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRd  output  1  memory read strobe
- MemWr  output  1  memory write strobe
- IRWrite  output  1  load IR
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by zero (BEQ)
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  output  1  0 = PC, 1 = reg A
- ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = decode funct
- RegDst  output  1  1 = rd, 0 = rt
- RegWr  output  1  register file write
- MemtoReg  output  1  1 = MDR, 0 = ALUOut
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal  output  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- States, 4-bit register: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP.
- rst=1: next state is FETCH and op_q is cleared. While rst=1, every output is forced to 0, including the Mealy terms.
- FETCH:
  - Drive MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1. The state then advances to DECODE; otherwise it stays in FETCH.
- DECODE:
  - Drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 to compute the branch target into ALUOut.
  - Latch op into op_q.
  - Next state by op: 000000→EXEC, 100011/101011→MEMADR, 000100→BRANCH, 000010→JUMP.
  - Any other op: pulse illegal and instr_done, then go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD if op_q=LW, else MEMWR.
- MEMRD: MemRd=1, IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegWr=1, RegDst=0, MemtoReg=1, instr_done=1. Next state is FETCH.
- MEMWR: MemWr=1, IorD=1. Hold until mem_ready=1; in that cycle pulse instr_done and go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- ALUWB: RegWr=1, RegDst=1, MemtoReg=0, instr_done=1. Next state is FETCH.
- BRANCH:
  - Drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWriteCond=1, instr_done=1. Next state is FETCH.
  - The datapath loads PC only when zero=1.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1. Next state is FETCH.
- Any output not listed for a state is 0 in that state.
- Any unreachable state encoding goes to FETCH on the next clock.

## Timing
- Apart from the FETCH and MEMWR mem_ready terms, outputs are combinational from the state register.
- State and op_q update on the rising edge of clk.
- Latency with mem_ready held at 1, in cycles from entering FETCH through the instr_done cycle: R=4, LW=5, SW=4, BEQ=3, J=3, illegal=2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRd and MemWr are held stable across the stall.
- rst asserted mid-instruction:
  - The current write (RegWr, MemWr, PCWrite) is suppressed in that cycle.
  - FETCH is entered on the next edge; no partial instruction resumes.
- The first cycle after rst deasserts is FETCH, with MemRd=1.
- op changes after DECODE have no effect, because routing uses op_q.

## Test plan
- Reset: hold rst=1 for 2 cycles with mem_ready=1 → all outputs 0. Release rst → next cycle MemRd=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type, op=000000, mem_ready=1 → states FETCH, DECODE, EXEC, ALUWB. Cycle 3 shows ALUOp=10. Cycle 4 shows RegWr=1, RegDst=1, instr_done=1.
- LW with stalls, op=100011, mem_ready=0 for 2 cycles in MEMRD → 7-cycle instruction. MemRd=1 and IorD=1 are held through the stall. MEMWB shows RegWr=1, MemtoReg=1.
- SW then BEQ:
  - SW (op=101011) → MemWr=1 only in MEMWR, instr_done pulses in the cycle where mem_ready=1.
  - BEQ (op=000100) → 3 cycles; BRANCH shows ALUOp=01, PCWriteCond=1, PCSrc=01.
- Jump and illegal:
  - op=000010 → JUMP shows PCWrite=1, PCSrc=10 in cycle 3.
  - op=111111 → illegal=1 and instr_done=1 in DECODE, then FETCH.
- Reset mid-LW: assert rst in MEMWB → RegWr=0 in that cycle, and FETCH on the next cycle after release.
